otter_muldiv: RTL

- Iterative RV32M multiply/divide unit. It is a peer execute stage to the OTTER ALU.
- It is fed from the same srcA/srcB operand muxes.
- Its result feeds the register-file writeback mux alongside the ALU output.
- The control unit stalls the pipeline while busy is high and selects the result when done pulses.

---
 rtl/otter_muldiv.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/otter_muldiv.sv
// otter_muldiv: iterative RV32M multiply/divide execute unit.
// One shift-add or restoring-divide step per clock, then a sign fix.
module otter_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   dvs;
  logic [2*XLEN-1:0] acc;

  logic            is_div;
  logic            a_sgn;
  logic            b_sgn;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            dz;
  logic            ovf;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  // decode request: signedness, magnitudes and divide short-cuts
  always_comb begin
    is_div = funct3[2];
    a_sgn  = (funct3 != 3'b011) && !(is_div && funct3[0]);
    b_sgn  = a_sgn && (funct3 != 3'b010);
    neg_a  = a_sgn && A[XLEN-1];
    neg_b  = b_sgn && B[XLEN-1];
    mag_a  = neg_a ? (~A + 1'b1) : A;
    mag_b  = neg_b ? (~B + 1'b1) : B;
    dz     = (B == '0);
    ovf    = !funct3[0] && (A == MINV) && (B == '1);
    fast   = is_div && (dz || ovf);
    if (dz) fast_res = funct3[1] ? A : '1;
    else    fast_res = funct3[1] ? '0 : A;
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_df;
  logic [2*XLEN-1:0] div_nxt;

  // one multiply step and one restoring-divide step on acc
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
            + (acc[0] ? {1'b0, dvs} : '0);
    mul_nxt = {mul_sum, acc[XLEN-1:1]};
    div_sh  = acc[2*XLEN-1:XLEN-1];
    div_df  = div_sh - {1'b0, dvs};
    if (div_df[XLEN])
      div_nxt = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_nxt = {div_df[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rmd;
  logic [XLEN-1:0]   fix_res;

  // sign correction and output select
  always_comb begin
    prod = (sa ^ sb) ? (~acc + 1'b1) : acc;
    quo  = (sa ^ sb) ? (~acc[XLEN-1:0] + 1'b1)
                     : acc[XLEN-1:0];
    rmd  = sa ? (~acc[2*XLEN-1:XLEN] + 1'b1)
              : acc[2*XLEN-1:XLEN];
    fix_res = '0;
    unique case (1'b1)
      (op == 3'b000):                 fix_res = prod[XLEN-1:0];
      (!op[2] && op[1:0] != 2'b00):   fix_res = prod[2*XLEN-1:XLEN];
      (op[2] && op[1]):               fix_res = rmd;
      (op[2] && !op[1]):              fix_res = quo;
      default:                        fix_res = '0;
    endcase
  end

  // control FSM and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dvs    <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (flush) begin
            state <= IDLE;
          end else if (start) begin
            op  <= funct3;
            sa  <= neg_a;
            sb  <= neg_b;
            cnt <= '0;
            if (fast) begin
              result <= fast_res;
              state  <= DONE;
            end else begin
              dvs   <= is_div ? mag_b : mag_a;
              acc   <= is_div ? {{XLEN{1'b0}}, mag_a}
                              : {{XLEN{1'b0}}, mag_b};
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= op[2] ? div_nxt : mul_nxt;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(XLEN - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            result <= fix_res;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule
